// File: rtl/alu_exec.sv
// Multi-cycle execute stage: latches operands on start, iterates in CALC, writes back for one cycle.
// Optional zero/carry flag outputs are built when ALU_EXEC_FLAGS_EN is defined.
module alu_exec #(
    parameter int unsigned pw = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [7:0]    datA,
    input  logic [7:0]    datB,
    input  logic [pw-1:0] dst,
    output logic          busy,
    output logic [7:0]    dat_in,
    output logic          wr_en,
    output logic [pw-1:0] wr_addr,
    output logic          done
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic          zero,
    output logic          carry
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic [1:0]    r_state;
    logic [2:0]    r_op;
    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic [15:0]   r_acc;
    logic [15:0]   r_mc;
    logic [2:0]    r_cnt;
    logic [pw-1:0] r_dst;
    logic [7:0]    r_dat;
    logic [pw-1:0] r_waddr;

    logic          w_shamt0;
    logic [15:0]   w_acc_nxt;
    logic [7:0]    w_result;
    logic [2:0]    w_cnt_init;
    logic          w_last;

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_WB);
    assign wr_en   = done && (r_op != OP_NOP);
    assign dat_in  = r_dat;
    assign wr_addr = r_waddr;
    assign w_last  = (r_state == ST_CALC) && (r_cnt == 3'd0);

    always_comb begin
        w_cnt_init = 3'd0;
        if (op == OP_MUL) begin
            w_cnt_init = 3'd7;
        end else if ((op == OP_SHL || op == OP_SHR) && datB[2:0] != 3'd0) begin
            w_cnt_init = datB[2:0] - 3'd1;
        end
    end

    // One iteration step: a single-bit shift, or one shift-add partial product (multiplier LSB first).
    always_comb begin
        w_shamt0  = (r_b[2:0] == 3'd0);
        w_acc_nxt = r_acc;
        case (r_op)
            OP_SHL:  if (!w_shamt0) w_acc_nxt = {8'h00, r_acc[6:0], 1'b0};
            OP_SHR:  if (!w_shamt0) w_acc_nxt = {8'h00, 1'b0, r_acc[7:1]};
            OP_MUL:  w_acc_nxt = r_acc + (r_b[0] ? r_mc : 16'h0000);
            default: w_acc_nxt = r_acc;
        endcase
    end

    always_comb begin
        w_result = 8'h00;
        case (r_op)
            OP_ADD:                 w_result = r_a + r_b;
            OP_SUB:                 w_result = r_a - r_b;
            OP_AND:                 w_result = r_a & r_b;
            OP_XOR:                 w_result = r_a ^ r_b;
            OP_SHL, OP_SHR, OP_MUL: w_result = w_acc_nxt[7:0];
            default:                w_result = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_acc   <= 16'h0000;
            r_mc    <= 16'h0000;
            r_cnt   <= 3'd0;
            r_dst   <= '0;
            r_dat   <= 8'h00;
            r_waddr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= datA;
                        r_b     <= datB;
                        r_dst   <= dst;
                        r_acc   <= (op == OP_MUL) ? 16'h0000 : {8'h00, datA};
                        r_mc    <= {8'h00, datA};
                        r_cnt   <= w_cnt_init;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_nxt;
                    if (r_op == OP_MUL) begin
                        r_mc <= {r_mc[14:0], 1'b0};
                        r_b  <= {1'b0, r_b[7:1]};
                    end
                    if (w_last) begin
                        r_dat   <= w_result;
                        r_waddr <= r_dst;
                        r_state <= ST_WB;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_WB:   r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_EXEC_FLAGS_EN
    logic r_zero;
    logic r_carry;
    logic w_carry;

    // Shifts: on the final iteration the bit about to leave r_acc is the last one shifted out.
    always_comb begin
        w_carry = 1'b0;
        case (r_op)
            OP_ADD:  w_carry = ({1'b0, r_a} + {1'b0, r_b}) > 9'd255;
            OP_SUB:  w_carry = (r_a >= r_b);
            OP_SHL:  w_carry = !w_shamt0 && r_acc[7];
            OP_SHR:  w_carry = !w_shamt0 && r_acc[0];
            OP_MUL:  w_carry = (w_acc_nxt[15:8] != 8'h00);
            default: w_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_last) begin
            r_zero  <= (w_result == 8'h00);
            r_carry <= w_carry;
        end
    end

    assign zero  = r_zero;
    assign carry = r_carry;
`endif

endmodule
